// File: rtl/counter_sequencer.sv
// counter_sequencer: drives a loadable up-counter through repeated start->end passes.
module counter_sequencer #(
  parameter int WIDTH = 5,
  parameter int RPT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] START_VAL,
  input  logic [WIDTH-1:0] END_VAL,
  input  logic [RPT_W-1:0] REPEAT,
  input  logic [WIDTH-1:0] COUNT,
  output logic             CNT_ENA,
  output logic             CNT_LOAD,
  output logic [WIDTH-1:0] CNT_DATA,
  output logic             CNT_RST_N,
  output logic             BUSY,
  output logic             DONE,
  output logic [RPT_W-1:0] PASS_CNT
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_end;
  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] r_pass;
  logic             r_cnt_rst_n;
  logic             w_match;
  logic             w_accept;
  logic             w_pass_end;
  always_comb begin
    w_match    = COUNT == r_end;
    w_accept   = r_state == S_IDLE && START && !ABORT;
    w_pass_end = r_state == S_RUN && w_match && !ABORT;
    w_next     = ABORT                ? S_IDLE :
                 r_state == S_IDLE    ? (START ? S_LOAD : S_IDLE) :
                 r_state == S_LOAD    ? S_RUN :
                 r_state == S_RUN     ? (w_match ? (r_pass == r_rpt ? S_DONE : S_LOAD) : S_RUN) :
                 S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_start     <= '0;
      r_end       <= '0;
      r_rpt       <= '0;
      r_pass      <= '0;
      r_cnt_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt_rst_n <= !ABORT;
      if (w_accept) begin
        r_start <= START_VAL;
        r_end   <= END_VAL;
        r_rpt   <= REPEAT;
        r_pass  <= '0;
      end
      if (w_pass_end) r_pass <= r_pass + 1'b1;
    end
  end
  // Enable drops combinationally on the match so the counter parks on the end value.
  always_comb begin
    CNT_LOAD  = r_state == S_LOAD;
    CNT_ENA   = CNT_LOAD || (r_state == S_RUN && !w_match);
    CNT_DATA  = CNT_LOAD ? r_start : '0;
    CNT_RST_N = r_cnt_rst_n;
    BUSY      = r_state == S_LOAD || r_state == S_RUN;
    DONE      = r_state == S_DONE;
    PASS_CNT  = r_pass;
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized scoreboard bench with an external counter model.
module tb_counter_sequencer;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [4:0] START_VAL = '0;
  logic [4:0] END_VAL = '0;
  logic [3:0] REPEAT = '0;
  logic [4:0] COUNT = '0;
  logic       CNT_ENA, CNT_LOAD, CNT_RST_N, BUSY, DONE;
  logic [4:0] CNT_DATA;
  logic [3:0] PASS_CNT;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int         cyc;
    logic [4:0] ctrl;
    logic       chk_cnt;
    logic [4:0] cnt;
    logic       chk_pass;
    logic [3:0] pass;
    logic [4:0] data;
  } rec_t;
  rec_t q[$];
  counter_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .START_VAL(START_VAL), .END_VAL(END_VAL), .REPEAT(REPEAT), .COUNT(COUNT),
    .CNT_ENA(CNT_ENA), .CNT_LOAD(CNT_LOAD), .CNT_DATA(CNT_DATA), .CNT_RST_N(CNT_RST_N),
    .BUSY(BUSY), .DONE(DONE), .PASS_CNT(PASS_CNT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // The team's 5-bit loadable counter.
  always @(posedge CLK) begin
    if (!CNT_RST_N) COUNT <= '0;
    else if (CNT_ENA) COUNT <= CNT_LOAD ? CNT_DATA : COUNT + 5'd1;
  end
  always @(negedge CLK) begin
    rec_t x;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      x = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL missed_check cyc=%0d got=none expected=checked", x.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      x = q.pop_front();
      n_vec++;
      if ({CNT_LOAD, CNT_ENA, BUSY, DONE, CNT_RST_N} !== x.ctrl) begin
        n_err++;
        $display("FAIL ctrl cyc=%0d got load/ena/busy/done/rstn=%b expected=%b", cyc,
                 {CNT_LOAD, CNT_ENA, BUSY, DONE, CNT_RST_N}, x.ctrl);
      end
      if (x.chk_cnt) begin
        n_vec++;
        if (COUNT !== x.cnt) begin
          n_err++;
          $display("FAIL count cyc=%0d got=%0d expected=%0d", cyc, COUNT, x.cnt);
        end
      end
      if (x.chk_pass) begin
        n_vec++;
        if (PASS_CNT !== x.pass) begin
          n_err++;
          $display("FAIL pass_cnt cyc=%0d got=%0d expected=%0d", cyc, PASS_CNT, x.pass);
        end
      end
      if (x.ctrl[4]) begin
        n_vec++;
        if (CNT_DATA !== x.data) begin
          n_err++;
          $display("FAIL cnt_data cyc=%0d got=%0d expected=%0d", cyc, CNT_DATA, x.data);
        end
      end
    end else if (DONE === 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_done cyc=%0d got=1 expected=0", cyc);
    end
  end
  task automatic push(input int c, input logic [4:0] ctrl, input logic chk_cnt, input logic [4:0] cnt,
                      input logic chk_pass, input logic [3:0] pass, input logic [4:0] data);
    rec_t x;
    x.cyc = c; x.ctrl = ctrl; x.chk_cnt = chk_cnt; x.cnt = cnt;
    x.chk_pass = chk_pass; x.pass = pass; x.data = data;
    q.push_back(x);
  endtask
  // mode 0: run to completion, 1: ABORT in cycle ka, 2: RST in cycle ka.
  task automatic run_cmd(input logic [4:0] s, input logic [4:0] e, input logic [3:0] r,
                         input int mode, input int ka);
    logic [4:0] d;
    logic [3:0] pf;
    int p, kd, kend, te, o;
    d    = e - s;
    p    = int'(d) + 2;
    kd   = 1 + (int'(r) + 1) * p;
    kend = (mode == 0) ? kd + 1 : ka + 2;
    pf   = (mode == 2) ? 4'd0 : 4'((ka - 1) / p);
    @(negedge CLK);
    START = 1'b1; START_VAL = s; END_VAL = e; REPEAT = r;
    @(posedge CLK);
    #1 te = cyc;
    for (int k = 1; k <= kend; k++) begin
      if (mode != 0 && k == ka + 1)
        push(te + k - 1, 5'b00000, 1'b0, 5'd0, 1'b1, pf, 5'd0);
      else if (mode != 0 && k == ka + 2)
        push(te + k - 1, 5'b00001, 1'b1, 5'd0, 1'b1, pf, 5'd0);
      else if (k < kd) begin
        o = (k - 1) % p;
        push(te + k - 1, {o == 0, o == 0 || (o - 1) != int'(d), 1'b1, 1'b0, 1'b1},
             k > 1, (o == 0) ? e : s + 5'(o - 1), 1'b1, 4'((k - 1) / p), s);
      end else
        push(te + k - 1, {3'b000, k == kd, 1'b1}, 1'b1, e, 1'b1, r + 4'd1, 5'd0);
    end
    for (int k = 1; k <= kend; k++) begin
      @(negedge CLK);
      START     = (k <= kd && (mode == 0 || k <= ka)) ? ($urandom_range(3) == 0) : 1'b0;
      START_VAL = 5'($urandom);
      END_VAL   = 5'($urandom);
      REPEAT    = 4'($urandom);
      ABORT     = mode == 1 && k == ka;
      RST       = mode == 2 && k == ka;
    end
  endtask
  initial begin
    logic [4:0] s, e;
    logic [3:0] r;
    int m, kd;
    push(1, 5'b00000, 1'b0, 5'd0, 1'b1, 4'd0, 5'd0);
    push(2, 5'b00000, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0);
    push(3, 5'b00001, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0);
    push(4, 5'b00000, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0);
    push(5, 5'b00001, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK) ABORT = 1'b1;
    @(negedge CLK) ABORT = 1'b0;
    run_cmd(5'd1, 5'd5, 4'd0, 0, 0);
    run_cmd(5'd28, 5'd2, 4'd1, 0, 0);
    run_cmd(5'd7, 5'd7, 4'd2, 0, 0);
    run_cmd(5'd0, 5'd20, 4'd0, 1, 12);
    run_cmd(5'd3, 5'd9, 4'd1, 2, 5);
    run_cmd(5'd30, 5'd1, 4'd15, 0, 0);
    for (int i = 0; i < 25; i++) begin
      s  = 5'($urandom);
      e  = 5'($urandom);
      r  = 4'($urandom_range(4));
      kd = 1 + (int'(r) + 1) * (int'(5'(e - s)) + 2);
      m  = ($urandom_range(9) < 7) ? 0 : int'($urandom_range(2, 1));
      run_cmd(s, e, r, m, (m == 0) ? 0 : int'($urandom_range(kd - 2)) + 1);
    end
    repeat (3) @(negedge CLK);
    while (q.size() > 0) begin
      void'(q.pop_front());
      n_vec++; n_err++;
      $display("FAIL leftover_check got=unchecked expected=checked");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
